// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter. It shifts out a latched PAT_W-bit pattern
// MSB-first and repeats it repeat_n times. An optional idle gap can be
// inserted between repetitions. Control is a start/busy/done handshake,
// with abort as a synchronous cancel.
module seq_pattern_tx #(
   parameter int PAT_W = 5,
   parameter int CNT_W = 4,
   parameter int GAP_W = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_n,
   input  logic [GAP_W-1:0] gap,
   input  logic             abort,
   output logic             out,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   localparam int BC_W = $clog2(PAT_W);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

   state_t           state, state_next;
   logic [PAT_W-1:0] shift_reg;
   logic [PAT_W-1:0] pat_copy;
   logic [BC_W-1:0]  bit_cnt;
   logic [CNT_W-1:0] rep_cnt;
   logic [GAP_W-1:0] gap_reg;
   logic [GAP_W-1:0] gap_cnt;

   // Datapath strobes decoded by the next-state logic
   logic load, reload, shift_en, gap_load, gap_dec;

   // State register, cleared asynchronously so outputs drop at once on RESET
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state decode; end of a repetition is when the bit counter hits zero
   always_comb begin
      state_next = state;
      load       = 1'b0;
      reload     = 1'b0;
      shift_en   = 1'b0;
      gap_load   = 1'b0;
      gap_dec    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (repeat_n != '0) begin
                  state_next = SHIFT;
                  load       = 1'b1;
               end else begin
                  state_next = DONE;
               end
            end
         end
         SHIFT: begin
            if (abort) begin
               state_next = IDLE;
            end else if (bit_cnt == '0) begin
               if (rep_cnt == CNT_W'(1)) begin
                  state_next = DONE;
               end else begin
                  reload = 1'b1;
                  if (gap_reg != '0) begin
                     state_next = GAP;
                     gap_load   = 1'b1;
                  end
               end
            end else begin
               shift_en = 1'b1;
            end
         end
         GAP: begin
            if (abort)                          state_next = IDLE;
            else if (gap_cnt == GAP_W'(1))      state_next = SHIFT;
            else                                gap_dec    = 1'b1;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Shift register, pattern copy and counters; reload uses the copy, never the live input
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         shift_reg <= '0;
         pat_copy  <= '0;
         bit_cnt   <= '0;
         rep_cnt   <= '0;
         gap_reg   <= '0;
         gap_cnt   <= '0;
      end else begin
         if (load) begin
            shift_reg <= pattern;
            pat_copy  <= pattern;
            bit_cnt   <= BC_W'(PAT_W - 1);
            rep_cnt   <= repeat_n;
            gap_reg   <= gap;
         end else if (reload) begin
            shift_reg <= pat_copy;
            bit_cnt   <= BC_W'(PAT_W - 1);
            rep_cnt   <= rep_cnt - CNT_W'(1);
         end else if (shift_en) begin
            shift_reg <= {shift_reg[PAT_W-2:0], 1'b0};
            bit_cnt   <= bit_cnt - BC_W'(1);
         end
         if (gap_load)     gap_cnt <= gap_reg;
         else if (gap_dec) gap_cnt <= gap_cnt - GAP_W'(1);
      end
   end

   // Moore outputs: a function of state and registered data only
   always_comb begin
      out   = 1'b0;
      valid = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      case (state)
         SHIFT: begin
            out   = shift_reg[PAT_W-1];
            valid = 1'b1;
            busy  = 1'b1;
         end
         GAP:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern generator: the transmit side of the team's serial sequence-detector blocks.
- Loads a PAT_W-bit pattern and shifts it out MSB-first, one bit per CLK, repeated a programmable number of times with an optional idle gap between repetitions.
- Drives the 1-bit serial input of a Moore sequence detector on-chip and on the FPGA bench (default pattern 11001).
- Provides a start/busy/done handshake to the controlling logic.

Parameters:
- PAT_W, 5, pattern length in bits (>=2).
- CNT_W, 4, width of repeat count.
- GAP_W, 4, width of inter-repetition gap count.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- pattern  in  PAT_W  bit pattern, latched on accepted start; bit PAT_W-1 is sent first.
- repeat_n  in  CNT_W  number of repetitions, latched on accepted start.
- gap  in  GAP_W  idle cycles between repetitions, latched on accepted start.
- abort  in  1  synchronous cancel.
- out  out  1  serial data.
- valid  out  1  high when out carries a pattern bit.
- busy  out  1  high from the accepting edge until the transfer ends.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset:
  - Reset is RESET, asynchronous, active-high; clock is CLK.
  - RESET forces state IDLE and clears the shift register, bit counter, repeat counter and gap counter.
  - out=0, valid=0, busy=0, done=0 immediately on RESET assertion, independent of CLK.
- States: IDLE, SHIFT, GAP, DONE. State is held in a 2- or 3-bit register. Outputs are a Moore function of state and registered data only; no input-to-output combinational path.
- IDLE:
  - out=0, valid=0, busy=0.
  - start=1 at an edge with repeat_n!=0: latch pattern into the shift register, load bit counter=PAT_W-1, repeat counter=repeat_n, gap register=gap; go to SHIFT.
  - start=1 with repeat_n==0: go to DONE, emitting no bits.
- SHIFT:
  - out = shift_reg[PAT_W-1], valid=1, busy=1.
  - Each edge shifts left by one and decrements the bit counter.
  - The first bit is visible in the cycle immediately after the accepting edge (latency 1 edge).
  - After PAT_W cycles in SHIFT:
    - Repeat counter==1: go to DONE.
    - Otherwise, decrement the repeat counter and reload the shift register from the latched pattern copy (not from the live pattern input).
    - Then, if gap==0, stay in SHIFT (back-to-back, no bubble); else go to GAP with gap counter=gap.
- GAP:
  - out=0, valid=0, busy=1.
  - Stay exactly gap cycles, then go to SHIFT with the first bit of the next repetition.
- DONE:
  - done=1, busy=0, valid=0, out=0, for exactly one cycle; then IDLE.
  - start during DONE is ignored.
- start while busy=1 is ignored; the latched parameters do not change.
- abort=1 at an edge in SHIFT or GAP: go to IDLE on that edge. No done pulse; outputs return to idle values the next cycle.
- abort in IDLE or DONE has no effect. If abort and start are both high in IDLE, start wins.
- Total valid cycles per transfer = repeat_n*PAT_W.
- Total busy cycles = repeat_n*PAT_W + (repeat_n-1)*gap.
- Counters never wrap: gap max 2^GAP_W-1, repeat max 2^CNT_W-1.
- Changes on pattern, repeat_n or gap while busy have no effect on the current transfer.

Test Plan:
- Single transfer: pattern=11001, repeat_n=1, gap=0, start pulse at edge 0. Required: out=1,1,0,0,1 with valid=1 in cycles 1-5; done=1 in cycle 6 only; busy=1 in cycles 1-5. Looped into the 11001 Moore detector, detector out=1 exactly once.
- Back-to-back: repeat_n=2, gap=0. Required: 10 consecutive valid bits 1100111001 with no valid gap; done in cycle 11. The detector fires twice (second detection via its overlap path).
- Gap: repeat_n=2, gap=3. Required: 5 bits, then 3 cycles valid=0 out=0 busy=1, then 5 bits; done in cycle 14; busy high for 13 cycles.
- Abort: repeat_n=3, gap=2, abort asserted at the 3rd bit of repetition 2. Required: IDLE next edge; valid, busy and out all 0 afterwards; done never asserted. A new start is then accepted normally.
- Ignored requests: start re-pulsed mid-transfer with a different pattern, and repeat_n=0. Required: the original transfer completes unchanged; repeat_n=0 yields no valid cycles and done the cycle after acceptance.
- RESET asynchronously between clock edges mid-SHIFT. Required: all outputs 0 before the next CLK edge; IDLE held until start.
